// File: rtl/mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : mult_pkg
// Purpose : Shared constants and state encoding for the shift-add multiplier
//           sequencer (mult_ctrl) and its iteration counter.
// Contents: WIDTH  - operand width (product is 2*WIDTH)
//           CNT_W  - iteration counter width
//           state_t- sequencer states IDLE / RUN / DONE
// Revision: 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: mult_ctrl_if
// Purpose  : Start/done request bus of the multiplier sequencer.
// Signals  : start        - request (requester -> sequencer)
//            multiplicand - operand A, captured on accepted start
//            multiplier   - operand B, captured on accepted start
//            busy         - sequencer is iterating
//            done         - one-cycle pulse, product valid
//            product      - 2*WIDTH result, held until next accepted start
// Modports : master (requester side), slave (sequencer side)
// Revision : 1.0 - initial release
// ============================================================================
interface mult_ctrl_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface : mult_ctrl_if
`default_nettype wire

// File: rtl/mult_iter_cnt.sv
`default_nettype none
// ============================================================================
// Module  : mult_iter_cnt
// Purpose : Iteration counter for the multiplier sequencer. Clear has
//           priority over increment; last_o flags the final iteration.
// Ports   : clk    - clock, rising edge
//           reset  - synchronous active-high reset
//           clr_i  - clear count to zero
//           inc_i  - advance count by one
//           cnt_o  - current count
//           last_o - count equals WIDTH-1 (final iteration in progress)
// Revision: 1.0 - initial release
// ============================================================================
module mult_iter_cnt
  import mult_pkg::*;
#(
  parameter int ITERS = 32,
  parameter int CW    = $clog2(ITERS) + 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          clr_i,
  input  wire logic          inc_i,
  output logic [CW-1:0]      cnt_o,
  output logic               last_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(ITERS - 1));

endmodule : mult_iter_cnt
`default_nettype wire

// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mult_ctrl
// Purpose : Self-timed sequencer for the shift-add multiplier. Accepts an
//           operand pair on the start/done bus, owns the 2*WIDTH product
//           register and steps the external combinational datapath once per
//           clock for WIDTH iterations.
// Ports   : clk       - clock, rising edge
//           reset     - synchronous active-high reset
//           bus       - start/done request bus (slave modport)
//           dp_mult   - registered multiplicand to datapath
//           dp_p      - current product register to datapath
//           dp_write  - add-enable to datapath (LSB of dp_p)
//           dp_p_next - next product value from datapath
// Options : MULT_CTRL_ZERO_BYPASS_EN - a start with a zero operand skips the
//           iterations and completes in DONE one edge after acceptance.
// Revision: 1.0 - initial release
// ============================================================================
module mult_ctrl #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  wire logic             clk,
  input  wire logic             reset,
  mult_ctrl_if.slave            bus,
  output logic [WIDTH-1:0]      dp_mult,
  output logic [2*WIDTH-1:0]    dp_p,
  output logic                  dp_write,
  input  wire logic [2*WIDTH-1:0] dp_p_next
);

  import mult_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   p_q;
  logic [WIDTH-1:0]     m_q;
  logic [2*WIDTH-1:0]   product_q;

  logic                 load;
  logic                 iter;
  logic                 last_iter;
  logic [CW-1:0]        cnt;
  logic                 zero_op;

`ifdef MULT_CTRL_ZERO_BYPASS_EN
  assign zero_op = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  mult_iter_cnt #(
    .ITERS (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (load),
    .inc_i  (iter),
    .cnt_o  (cnt),
    .last_o (last_iter)
  );

  // The count itself is only consumed through last_o.
  logic cnt_unused;
  assign cnt_unused = ^cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    iter    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        iter = 1'b1;
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Product is cleared on acceptance so a bypassed zero operand yields 0
  // without touching the iteration path.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q       <= '0;
      m_q       <= '0;
      product_q <= '0;
    end else if (load) begin
      p_q       <= {{WIDTH{1'b0}}, bus.multiplier};
      m_q       <= bus.multiplicand;
      product_q <= '0;
    end else if (iter) begin
      p_q <= dp_p_next;
      if (last_iter) begin
        product_q <= dp_p_next;
      end
    end
  end

  assign dp_mult     = m_q;
  assign dp_p        = p_q;
  assign dp_write    = p_q[0];
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule : mult_ctrl
`default_nettype wire
